dbus_wb_master: RTL



---
 rtl/dbus_wb_master.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/dbus_wb_master.sv
// dbus_wb_master: data-side Wishbone B3 master; one single read/write per MEM-stage request,
// with stall handshake, flush abort and an optional bus watchdog.
`default_nettype none

module dbus_wb_master #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic        cpu_ce_i,
    input  logic        cpu_we_i,
    input  logic [3:0]  cpu_sel_i,
    input  logic [31:0] cpu_addr_i,
    input  logic [31:0] cpu_data_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq,
    output logic        bus_err_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i
);

    // A zero TIMEOUT still needs a 1-bit counter so the declaration stays legal.
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TCNT_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam logic [TW-1:0] TCNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE           = 2'd0,
        BUSY           = 2'd1,
        WAIT_FOR_STALL = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic          we_q, we_d;
    logic [3:0]    sel_q, sel_d;
    logic          stb_q, stb_d;
    logic          cyc_q, cyc_d;
    logic [31:0]   rd_buf_q, rd_buf_d;
    logic [TW-1:0] tcnt_q, tcnt_d;

    logic          stall_any;
    assign stall_any = |stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            adr_q    <= '0;
            dat_q    <= '0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            stb_q    <= 1'b0;
            cyc_q    <= 1'b0;
            rd_buf_q <= '0;
            tcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            stb_q    <= stb_d;
            cyc_q    <= cyc_d;
            rd_buf_q <= rd_buf_d;
            tcnt_q   <= tcnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        we_d       = we_q;
        sel_d      = sel_q;
        stb_d      = stb_q;
        cyc_d      = cyc_q;
        rd_buf_d   = rd_buf_q;
        tcnt_d     = tcnt_q;
        stallreq   = 1'b0;
        cpu_data_o = '0;
        bus_err_o  = 1'b0;

        case (state_q)
            IDLE: begin
                stallreq = cpu_ce_i & ~flush;
                if (cpu_ce_i && !flush) begin
                    adr_d    = cpu_addr_i;
                    dat_d    = cpu_data_i;
                    we_d     = cpu_we_i;
                    sel_d    = cpu_sel_i;
                    stb_d    = 1'b1;
                    cyc_d    = 1'b1;
                    rd_buf_d = '0;
                    tcnt_d   = '0;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (wb_ack_i) begin
                    // Ack takes priority over a same-cycle flush: the transfer already happened.
                    adr_d      = '0;
                    dat_d      = '0;
                    we_d       = 1'b0;
                    sel_d      = '0;
                    stb_d      = 1'b0;
                    cyc_d      = 1'b0;
                    if (!we_q) begin
                        rd_buf_d = wb_dat_i;
                    end
                    cpu_data_o = we_q ? 32'd0 : wb_dat_i;
                    state_d    = stall_any ? WAIT_FOR_STALL : IDLE;
                end else if (flush) begin
                    adr_d    = '0;
                    dat_d    = '0;
                    we_d     = 1'b0;
                    sel_d    = '0;
                    stb_d    = 1'b0;
                    cyc_d    = 1'b0;
                    rd_buf_d = '0;
                    stallreq = 1'b1;
                    state_d  = IDLE;
                end else if ((TIMEOUT != 0) && (tcnt_q == TCNT_LAST)) begin
                    adr_d     = '0;
                    dat_d     = '0;
                    we_d      = 1'b0;
                    sel_d     = '0;
                    stb_d     = 1'b0;
                    cyc_d     = 1'b0;
                    bus_err_o = 1'b1;
                    state_d   = stall_any ? WAIT_FOR_STALL : IDLE;
                end else begin
                    stallreq = 1'b1;
                    if (tcnt_q != TCNT_MAX) begin
                        tcnt_d = tcnt_q + 1'b1;
                    end
                end
            end
            WAIT_FOR_STALL: begin
                cpu_data_o = rd_buf_q;
                if (!stall_any) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Combinational outputs are held quiet while reset is asserted.
        if (rst) begin
            stallreq   = 1'b0;
            cpu_data_o = '0;
            bus_err_o  = 1'b0;
        end
    end

    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_we_o  = we_q;
    assign wb_sel_o = sel_q;
    assign wb_stb_o = stb_q;
    assign wb_cyc_o = cyc_q;

endmodule

`default_nettype wire
